// File: rtl/csr_pkg.sv
// Machine-mode CSR addresses, mstatus layout and write-legalisation helpers.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;

   localparam int unsigned MSTATUS_MIE_BIT  = 3;
   localparam int unsigned MSTATUS_MPIE_BIT = 7;
   localparam int unsigned MSTATUS_MPP_LO   = 11;
   localparam int unsigned MSTATUS_MPP_HI   = 12;

   localparam logic [1:0] PRIV_M   = 2'b11;
   localparam logic [1:0] PRIV_U   = 2'b00;
   localparam logic [1:0] MPP_RSVD = 2'b10;

   typedef struct packed {
      logic [50:0] rsvd_63_13;
      logic [1:0]  mpp;
      logic [2:0]  rsvd_10_8;
      logic        mpie;
      logic [2:0]  rsvd_6_4;
      logic        mie;
      logic [2:0]  rsvd_2_0;
   } mstatus_t;

   function automatic logic [1:0] legal_mpp(input logic [1:0] mpp);
      if (mpp == MPP_RSVD) begin
         return PRIV_U;
      end else begin
         return mpp;
      end
   endfunction

   // Modes 2 and 3 are reserved; they collapse to direct mode.
   function automatic logic [63:0] legal_mtvec(input logic [63:0] value);
      if (value[1]) begin
         return {value[63:2], 2'b00};
      end else begin
         return value;
      end
   endfunction

   function automatic logic [63:0] legal_mepc(input logic [63:0] value);
      return {value[63:2], 2'b00};
   endfunction

   function automatic mstatus_t pack_mstatus(input logic       mie,
                                             input logic       mpie,
                                             input logic [1:0] mpp);
      mstatus_t s;
      s      = mstatus_t'(64'h0);
      s.mie  = mie;
      s.mpie = mpie;
      s.mpp  = mpp;
      return s;
   endfunction

endpackage

// File: rtl/pipes_pkg.sv
// Shared pipeline types exchanged between the commit stage and the CSR file.
package pipes;

   typedef struct packed {
      logic [63:0] mstatus;
      logic [63:0] mtvec;
      logic [63:0] mepc;
      logic [63:0] mcause;
   } excep_data_t;

endpackage

// File: rtl/csr_file.sv
// Machine-mode CSR file: trap entry/return, privilege tracking, counters and
// the redirect request that steers fetch to the trap vector or mepc.
module csr_file
   import pipes::*;
   import csr_pkg::*;
#(
   parameter logic [63:0] RESET_MTVEC = 64'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [11:0] csr_raddr,
   output logic [63:0] csr_data,
   output excep_data_t excep_rdata,
   input  logic        csr_wvalid,
   input  logic [11:0] csr_waddr,
   input  logic [63:0] csr_wdata,
   input  logic        trap_valid,
   input  logic [63:0] trap_cause,
   input  logic [63:0] trap_pc,
   input  logic [63:0] trap_tval,
   input  logic        mret_valid,
   input  logic        instr_retire,
   output logic        redirect_valid,
   output logic [63:0] redirect_pc,
   output logic [1:0]  priv_mode
);

   logic        r_mstatus_mie;
   logic        r_mstatus_mpie;
   logic [1:0]  r_mstatus_mpp;
   logic [1:0]  r_priv;
   logic [63:0] r_mie;
   logic [63:0] r_mtvec;
   logic [63:0] r_mscratch;
   logic [63:0] r_mepc;
   logic [63:0] r_mcause;
   logic [63:0] r_mtval;
   logic [63:0] r_mcycle;
   logic [63:0] r_minstret;

   mstatus_t    w_mstatus;
   logic        w_csr_we;
   logic        w_we_mstatus;
   logic        w_we_mie;
   logic        w_we_mtvec;
   logic        w_we_mscratch;
   logic        w_we_mepc;
   logic        w_we_mcause;
   logic        w_we_mtval;
   logic        w_we_mcycle;
   logic        w_we_minstret;
   logic [63:0] w_vec_base;
   logic [63:0] w_vec_off;
   logic        w_vectored;

   // A trap or mret in the same cycle swallows any CSR write.
   assign w_csr_we      = csr_wvalid & ~trap_valid & ~mret_valid;
   assign w_we_mstatus  = w_csr_we & (csr_waddr == CSR_MSTATUS);
   assign w_we_mie      = w_csr_we & (csr_waddr == CSR_MIE);
   assign w_we_mtvec    = w_csr_we & (csr_waddr == CSR_MTVEC);
   assign w_we_mscratch = w_csr_we & (csr_waddr == CSR_MSCRATCH);
   assign w_we_mepc     = w_csr_we & (csr_waddr == CSR_MEPC);
   assign w_we_mcause   = w_csr_we & (csr_waddr == CSR_MCAUSE);
   assign w_we_mtval    = w_csr_we & (csr_waddr == CSR_MTVAL);
   assign w_we_mcycle   = w_csr_we & (csr_waddr == CSR_MCYCLE);
   assign w_we_minstret = w_csr_we & (csr_waddr == CSR_MINSTRET);

   assign w_mstatus  = pack_mstatus(r_mstatus_mie, r_mstatus_mpie, r_mstatus_mpp);
   assign w_vec_base = {r_mtvec[63:2], 2'b00};
   assign w_vec_off  = {1'b0, trap_cause[62:0]} << 2'd2;
   assign w_vectored = (r_mtvec[1:0] == 2'b01) & trap_cause[63];
   assign priv_mode  = r_priv;

   // mstatus fields and current privilege: trap entry, mret, then SW writes.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= 1'b0;
         r_mstatus_mpp  <= PRIV_U;
         r_priv         <= PRIV_M;
      end else if (trap_valid) begin
         r_mstatus_mie  <= 1'b0;
         r_mstatus_mpie <= r_mstatus_mie;
         r_mstatus_mpp  <= r_priv;
         r_priv         <= PRIV_M;
      end else if (mret_valid) begin
         r_mstatus_mie  <= r_mstatus_mpie;
         r_mstatus_mpie <= 1'b1;
         r_mstatus_mpp  <= PRIV_U;
         r_priv         <= r_mstatus_mpp;
      end else if (w_we_mstatus) begin
         r_mstatus_mie  <= csr_wdata[MSTATUS_MIE_BIT];
         r_mstatus_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
         r_mstatus_mpp  <= legal_mpp(csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
      end else begin
         r_priv <= r_priv;
      end
   end

   // Trap record registers, loaded on trap entry or by software.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mepc   <= 64'h0;
         r_mcause <= 64'h0;
         r_mtval  <= 64'h0;
      end else if (trap_valid) begin
         r_mepc   <= trap_pc;
         r_mcause <= trap_cause;
         r_mtval  <= trap_tval;
      end else begin
         if (w_we_mepc) begin
            r_mepc <= legal_mepc(csr_wdata);
         end
         if (w_we_mcause) begin
            r_mcause <= csr_wdata;
         end
         if (w_we_mtval) begin
            r_mtval <= csr_wdata;
         end
      end
   end

   // Software-only registers: mie, mtvec, mscratch.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mie      <= 64'h0;
         r_mtvec    <= RESET_MTVEC;
         r_mscratch <= 64'h0;
      end else begin
         if (w_we_mie) begin
            r_mie <= csr_wdata;
         end
         if (w_we_mtvec) begin
            r_mtvec <= legal_mtvec(csr_wdata);
         end
         if (w_we_mscratch) begin
            r_mscratch <= csr_wdata;
         end
      end
   end

   // Free-running counters; a software write wins over the increment.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_mcycle   <= 64'h0;
         r_minstret <= 64'h0;
      end else begin
         if (w_we_mcycle) begin
            r_mcycle <= csr_wdata;
         end else begin
            r_mcycle <= r_mcycle + 64'd1;
         end
         if (w_we_minstret) begin
            r_minstret <= csr_wdata;
         end else if (instr_retire) begin
            r_minstret <= r_minstret + 64'd1;
         end else begin
            r_minstret <= r_minstret;
         end
      end
   end

   // Decode-stage read port; registered state only, no write bypass.
   always_comb begin
      csr_data = 64'h0;
      case (csr_raddr)
         CSR_MSTATUS:  csr_data = w_mstatus;
         CSR_MIE:      csr_data = r_mie;
         CSR_MTVEC:    csr_data = r_mtvec;
         CSR_MSCRATCH: csr_data = r_mscratch;
         CSR_MEPC:     csr_data = r_mepc;
         CSR_MCAUSE:   csr_data = r_mcause;
         CSR_MTVAL:    csr_data = r_mtval;
         CSR_MIP:      csr_data = 64'h0;
         CSR_MCYCLE:   csr_data = r_mcycle;
         CSR_MINSTRET: csr_data = r_minstret;
         default:      csr_data = 64'h0;
      endcase
   end

   // Redirect target: trap vector (optionally vectored) or mepc on mret.
   always_comb begin
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      if (reset) begin
         redirect_valid = 1'b0;
         redirect_pc    = 64'h0;
      end else if (trap_valid) begin
         redirect_valid = 1'b1;
         redirect_pc    = w_vectored ? (w_vec_base + w_vec_off) : w_vec_base;
      end else if (mret_valid) begin
         redirect_valid = 1'b1;
         redirect_pc    = r_mepc;
      end else begin
         redirect_valid = 1'b0;
         redirect_pc    = 64'h0;
      end
   end

   // Exception-unit view of the trap state.
   always_comb begin
      excep_rdata.mstatus = w_mstatus;
      excep_rdata.mtvec   = r_mtvec;
      excep_rdata.mepc    = r_mepc;
      excep_rdata.mcause  = 64'h0;
   end

endmodule
